// File: rtl/lfsr_checker_if.sv
// Stream interface between an LFSR word generator and the sequence checker.
// The master drives words and clear; the slave reports lock and error status.
interface lfsr_checker_if;
  logic        data_valid;
  logic [31:0] data_in;
  logic        clear;
  logic        locked;
  logic        error;
  logic [15:0] error_count;
  logic [31:0] word_count;

  modport master (
    output data_valid, data_in, clear,
    input  locked, error, error_count, word_count
  );

  modport slave (
    input  data_valid, data_in, clear,
    output locked, error, error_count, word_count
  );
endinterface

// File: rtl/lfsr_checker.sv
// Checks a 32-bit LFSR word stream (taps 32,22,2,1).
// In SEARCH it hunts for LOCK_COUNT consecutive in-sequence words.
// In LOCKED it predicts every word, flagging and counting mismatches.
// It falls back to SEARCH after LOSS_COUNT consecutive misses.
module lfsr_checker #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  lfsr_checker_if.slave bus
);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [31:0] EXPECTED_SEED = 32'h0000ACE1;

  state_t      state,         state_next;
  logic [31:0] prev,          prev_next;
  logic        prev_valid,    prev_valid_next;
  logic [3:0]  run,           run_next;
  logic [3:0]  miss_run,      miss_run_next;
  logic [31:0] expected,      expected_next;
  logic        error_r,       error_next;
  logic [15:0] error_count_r, error_count_next;
  logic [31:0] word_count_r,  word_count_next;

  logic [3:0]  run_inc;
  logic [3:0]  miss_inc;

  // One step of the generator polynomial: shift left, feed back the tap XOR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  assign run_inc  = run + 4'd1;
  assign miss_inc = miss_run + 4'd1;

  // Next-state and datapath decisions; clear outranks any word presented with it.
  always_comb begin
    state_next       = state;
    prev_next        = prev;
    prev_valid_next  = prev_valid;
    run_next         = run;
    miss_run_next    = miss_run;
    expected_next    = expected;
    error_next       = 1'b0;
    error_count_next = error_count_r;
    word_count_next  = word_count_r;

    if (bus.clear) begin
      state_next       = SEARCH;
      prev_next        = 32'h0;
      prev_valid_next  = 1'b0;
      run_next         = 4'd0;
      miss_run_next    = 4'd0;
      error_count_next = 16'h0;
      word_count_next  = 32'h0;
    end else if (bus.data_valid) begin
      unique case (state)
        SEARCH: begin
          prev_next       = bus.data_in;
          prev_valid_next = 1'b1;
          if (prev_valid && (bus.data_in != 32'h0) &&
              (bus.data_in == lfsr_next(prev))) begin
            run_next = run_inc;
            if (run_inc == 4'(LOCK_COUNT - 1)) begin
              state_next    = LOCKED;
              expected_next = lfsr_next(bus.data_in);
              miss_run_next = 4'd0;
            end
          end else begin
            run_next = 4'd0;
          end
        end

        LOCKED: begin
          expected_next   = lfsr_next(expected);
          word_count_next = word_count_r + 32'd1;
          if (bus.data_in == expected) begin
            miss_run_next = 4'd0;
          end else begin
            error_next    = 1'b1;
            miss_run_next = miss_inc;
            if (error_count_r != 16'hFFFF) begin
              error_count_next = error_count_r + 16'd1;
            end
            if (miss_inc == 4'(LOSS_COUNT)) begin
              state_next      = SEARCH;
              run_next        = 4'd0;
              prev_next       = bus.data_in;
              prev_valid_next = 1'b1;
            end
          end
        end

        default: begin
          state_next = SEARCH;
        end
      endcase
    end
  end

  // State register for the FSM and all checker datapath registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state         <= SEARCH;
      prev          <= 32'h0;
      prev_valid    <= 1'b0;
      run           <= 4'd0;
      miss_run      <= 4'd0;
      expected      <= EXPECTED_SEED;
      error_r       <= 1'b0;
      error_count_r <= 16'h0;
      word_count_r  <= 32'h0;
    end else begin
      state         <= state_next;
      prev          <= prev_next;
      prev_valid    <= prev_valid_next;
      run           <= run_next;
      miss_run      <= miss_run_next;
      expected      <= expected_next;
      error_r       <= error_next;
      error_count_r <= error_count_next;
      word_count_r  <= word_count_next;
    end
  end

  assign bus.locked      = (state == LOCKED);
  assign bus.error       = error_r;
  assign bus.error_count = error_count_r;
  assign bus.word_count  = word_count_r;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker.
// The main instance uses the default parameters.
// A second instance (LOCK_COUNT=2, LOSS_COUNT=15) stays locked while
// taking 14 of every 15 words wrong, which drives error_count to saturation.
module tb_lfsr_checker;

  typedef struct {
    string       tag;
    logic        locked;
    logic        error;
    logic [15:0] error_count;
    logic [31:0] word_count;
  } expect_t;

  logic ACLK;
  logic ARESETn;

  lfsr_checker_if main_bus ();
  lfsr_checker_if sat_bus ();

  lfsr_checker dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (main_bus)
  );

  lfsr_checker #(
    .LOCK_COUNT (2),
    .LOSS_COUNT (15)
  ) dut_sat (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (sat_bus)
  );

  int unsigned total_count = 0;
  int unsigned bad_count   = 0;
  expect_t     exp_q[$];

  logic [31:0] seq;
  logic [15:0] ec;
  logic [31:0] wc;
  logic [31:0] s;
  int unsigned sat_err;

  // Free-running clock.
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  function automatic logic [31:0] nextWord(input logic [31:0] x);
    logic fb;
    fb = x[31] ^ x[21] ^ x[1] ^ x[0];
    return (x << 1) | {31'h0, fb};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_count++;
    if (observed !== expected) begin
      bad_count++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one cycle on the main bus, queue what the outputs must show
  // after the edge, then pop and compare once the edge has passed.
  task automatic applyStimulus(input logic valid, input logic [31:0] data,
                               input logic clr, input logic e_locked,
                               input logic e_error, input logic [15:0] e_ec,
                               input logic [31:0] e_wc, input string tag);
    expect_t e;
    main_bus.data_valid = valid;
    main_bus.data_in    = data;
    main_bus.clear      = clr;
    e.tag         = tag;
    e.locked      = e_locked;
    e.error       = e_error;
    e.error_count = e_ec;
    e.word_count  = e_wc;
    exp_q.push_back(e);
    @(posedge ACLK);
    #1;
    e = exp_q.pop_front();
    checkOutput({e.tag, ".locked"}, {31'h0, main_bus.locked}, {31'h0, e.locked});
    checkOutput({e.tag, ".error"}, {31'h0, main_bus.error}, {31'h0, e.error});
    checkOutput({e.tag, ".error_count"}, {16'h0, main_bus.error_count},
                {16'h0, e.error_count});
    checkOutput({e.tag, ".word_count"}, main_bus.word_count, e.word_count);
  endtask

  task automatic satWord(input logic [31:0] data);
    sat_bus.data_valid = 1'b1;
    sat_bus.data_in    = data;
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    ARESETn             = 1'b0;
    main_bus.data_valid = 1'b0;
    main_bus.data_in    = 32'h0;
    main_bus.clear      = 1'b0;
    sat_bus.data_valid  = 1'b0;
    sat_bus.data_in     = 32'h0;
    sat_bus.clear       = 1'b0;

    #12;
    checkOutput("reset.locked", {31'h0, main_bus.locked}, 32'h0);
    checkOutput("reset.error", {31'h0, main_bus.error}, 32'h0);
    checkOutput("reset.error_count", {16'h0, main_bus.error_count}, 32'h0);
    checkOutput("reset.word_count", main_bus.word_count, 32'h0);
    #9;
    ARESETn = 1'b1;

    ec = 16'h0;
    wc = 32'h0;
    applyStimulus(1'b1, 32'h0000ACE1, 1'b0, 1'b0, 1'b0, ec, wc, "lock1");
    applyStimulus(1'b1, 32'h000159C3, 1'b0, 1'b0, 1'b0, ec, wc, "lock2");
    applyStimulus(1'b1, 32'h0002B386, 1'b0, 1'b0, 1'b0, ec, wc, "lock3");
    seq = nextWord(32'h0002B386);
    applyStimulus(1'b1, seq, 1'b0, 1'b1, 1'b0, ec, wc, "lock4");
    seq = nextWord(seq);

    for (int i = 0; i < 3; i++) begin
      wc++;
      applyStimulus(1'b1, seq, 1'b0, 1'b1, 1'b0, ec, wc, "track");
      seq = nextWord(seq);
    end

    wc++;
    ec++;
    applyStimulus(1'b1, seq ^ 32'h1, 1'b0, 1'b1, 1'b1, ec, wc, "corrupt");
    seq = nextWord(seq);
    applyStimulus(1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, ec, wc, "gap_locked");
    for (int i = 0; i < 5; i++) begin
      wc++;
      applyStimulus(1'b1, seq, 1'b0, 1'b1, 1'b0, ec, wc, "resume");
      seq = nextWord(seq);
    end

    for (int i = 0; i < 3; i++) begin
      wc++;
      ec++;
      applyStimulus(1'b1, 32'h0, 1'b0, (i < 2), 1'b1, ec, wc, "loss");
    end

    seq = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, seq, 1'b0, (i == 3), 1'b0, ec, wc, "relock");
      seq = nextWord(seq);
    end

    ec = 16'h0;
    wc = 32'h0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, ec, wc, "clear_idle");

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, ec, wc, "zero");
    end

    seq = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      int unsigned gaps;
      gaps = $urandom_range(0, 3);
      for (int g = 0; g < int'(gaps); g++) begin
        applyStimulus(1'b0, $urandom, 1'b0, 1'b0, 1'b0, ec, wc, "gap_search");
      end
      applyStimulus(1'b1, seq, 1'b0, (i == 3), 1'b0, ec, wc, "gap_lock");
      seq = nextWord(seq);
    end

    for (int i = 0; i < 2; i++) begin
      wc++;
      applyStimulus(1'b1, seq, 1'b0, 1'b1, 1'b0, ec, wc, "pre_clear");
      seq = nextWord(seq);
    end
    wc++;
    ec++;
    applyStimulus(1'b1, ~seq, 1'b0, 1'b1, 1'b1, ec, wc, "pre_clear_bad");
    seq = nextWord(seq);

    ec = 16'h0;
    wc = 32'h0;
    applyStimulus(1'b1, seq, 1'b1, 1'b0, 1'b0, ec, wc, "clear_word");
    seq = nextWord(seq);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, seq, 1'b0, (i == 3), 1'b0, ec, wc, "post_clear");
      seq = nextWord(seq);
    end
    main_bus.data_valid = 1'b0;

    s = 32'h0BADF00D;
    satWord(s);
    s = nextWord(s);
    satWord(s);
    s = nextWord(s);
    checkOutput("sat.lock", {31'h0, sat_bus.locked}, 32'h1);
    sat_err = 0;
    while (sat_err < 65540) begin
      for (int j = 0; j < 15; j++) begin
        if (j < 14) begin
          satWord(32'h0);
          sat_err++;
        end else begin
          satWord(s);
        end
        s = nextWord(s);
      end
      if (sat_err == 14) begin
        checkOutput("sat.first_block", {16'h0, sat_bus.error_count}, 32'd14);
      end
    end
    sat_bus.data_valid = 1'b0;
    checkOutput("sat.error_count", {16'h0, sat_bus.error_count}, 32'h0000FFFF);
    checkOutput("sat.locked", {31'h0, sat_bus.locked}, 32'h1);
    checkOutput("sat.error", {31'h0, sat_bus.error}, 32'h0);

    applyStimulus(1'b1, seq ^ 32'h80000000, 1'b0, 1'b1, 1'b1, 16'd1, 32'd1,
                  "pre_reset");
    #3;
    ARESETn = 1'b0;
    #1;
    checkOutput("async_reset.locked", {31'h0, main_bus.locked}, 32'h0);
    checkOutput("async_reset.error", {31'h0, main_bus.error}, 32'h0);
    checkOutput("async_reset.error_count", {16'h0, main_bus.error_count}, 32'h0);
    checkOutput("async_reset.word_count", main_bus.word_count, 32'h0);
    checkOutput("async_reset.sat_count", {16'h0, sat_bus.error_count}, 32'h0);
    checkOutput("async_reset.sat_locked", {31'h0, sat_bus.locked}, 32'h0);

    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule
